// File: rtl/fm_wb_collector.sv
// Write-back collector: packs per-row fm bytes into SRAM words and round-robins
// the completed words onto one SRAM write port; done_o pulses when every row is flushed.
module fm_wb_collector #(
  parameter int ROWS       = 8,
  parameter int WORD_BYTES = 8,
  parameter int ADDR_W     = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [ROWS*ADDR_W-1:0]    base_addr_i,
  input  logic [ROWS*8-1:0]         write_back_data_i,
  input  logic [ROWS-1:0]           write_back_data_i_valid,
  output logic [ROWS-1:0]           fm_buf_ready,
  input  logic [ROWS-1:0]           write_back_finish,
  output logic                      sram_wr_en,
  output logic [ADDR_W-1:0]         sram_wr_addr,
  output logic [WORD_BYTES*8-1:0]   sram_wr_data,
  output logic [WORD_BYTES-1:0]     sram_wr_mask,
  output logic                      done_o
);

  localparam int CW = $clog2(WORD_BYTES);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

  state_t                    state_r;
  logic [CW-1:0]             byte_cnt_r  [ROWS];
  logic [WORD_BYTES*8-1:0]   word_buf_r  [ROWS];
  logic [WORD_BYTES-1:0]     word_mask_r [ROWS];
  logic [ADDR_W-1:0]         addr_r      [ROWS];
  logic [ROWS-1:0]           pend_r;
  logic [ROWS-1:0]           flush_r;
  logic [ROWS-1:0]           row_done_r;
  logic [RW-1:0]             rr_ptr_r;
  logic [RW-1:0]             wr_row_r;

  logic                      gnt_vld_s;
  logic [RW-1:0]             gnt_row_s;
  logic [RW-1:0]             gnt_next_s;
  logic [ROWS-1:0]           inflight_s;
  logic [ROWS-1:0]           accept_s;

  // Byte-enable covering lanes [cnt-1:0]
  function automatic logic [WORD_BYTES-1:0] lane_mask(input logic [CW-1:0] cnt);
    logic [WORD_BYTES-1:0] m;
    m = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      m[k] = (k < int'(cnt));
    end
    return m;
  endfunction

  // Widen a byte mask to a bit mask so stale lanes of the buffer never reach the SRAM
  function automatic logic [WORD_BYTES*8-1:0] lane_expand(input logic [WORD_BYTES-1:0] m);
    logic [WORD_BYTES*8-1:0] e;
    e = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      e[k*8 +: 8] = {8{m[k]}};
    end
    return e;
  endfunction

  // Per-row ready, accept strobes and the row whose word is on the SRAM port this cycle
  always_comb begin
    fm_buf_ready = '0;
    inflight_s   = '0;
    if (state_r == ACTIVE) begin
      fm_buf_ready = ~pend_r & ~row_done_r;
    end else begin
      fm_buf_ready = '0;
    end
    accept_s = write_back_data_i_valid & fm_buf_ready;
    if (sram_wr_en) begin
      inflight_s[wr_row_r] = 1'b1;
    end else begin
      inflight_s = '0;
    end
  end

  // Round-robin pick among pending rows; a row stays pending through its write cycle
  always_comb begin
    logic [RW:0] sum_s;
    logic [RW-1:0] idx_s;
    gnt_vld_s = 1'b0;
    gnt_row_s = '0;
    sum_s     = '0;
    idx_s     = '0;
    for (int i = 0; i < ROWS; i++) begin
      sum_s = {1'b0, rr_ptr_r} + (RW+1)'(i);
      if (sum_s >= (RW+1)'(ROWS)) begin
        sum_s = sum_s - (RW+1)'(ROWS);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[RW-1:0];
      if (!gnt_vld_s && pend_r[idx_s] && !inflight_s[idx_s]) begin
        gnt_vld_s = 1'b1;
        gnt_row_s = idx_s;
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
    if (gnt_row_s == RW'(ROWS-1)) begin
      gnt_next_s = '0;
    end else begin
      gnt_next_s = gnt_row_s + RW'(1'b1);
    end
  end

  // Layer FSM, per-row packing/flush state and the registered SRAM write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      pend_r       <= '0;
      flush_r      <= '0;
      row_done_r   <= '0;
      rr_ptr_r     <= '0;
      wr_row_r     <= '0;
      sram_wr_en   <= 1'b0;
      sram_wr_addr <= '0;
      sram_wr_data <= '0;
      sram_wr_mask <= '0;
      done_o       <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        byte_cnt_r[r]  <= '0;
        word_buf_r[r]  <= '0;
        word_mask_r[r] <= '0;
        addr_r[r]      <= '0;
      end
    end else begin
      sram_wr_en <= gnt_vld_s;
      done_o     <= 1'b0;
      if (gnt_vld_s) begin
        sram_wr_addr      <= addr_r[gnt_row_s];
        sram_wr_data      <= word_buf_r[gnt_row_s] & lane_expand(word_mask_r[gnt_row_s]);
        sram_wr_mask      <= word_mask_r[gnt_row_s];
        wr_row_r          <= gnt_row_s;
        rr_ptr_r          <= gnt_next_s;
        addr_r[gnt_row_s] <= addr_r[gnt_row_s] + ADDR_W'(1'b1);
      end else begin
        wr_row_r <= wr_row_r;
      end

      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_r    <= ACTIVE;
            pend_r     <= '0;
            flush_r    <= '0;
            row_done_r <= '0;
            for (int r = 0; r < ROWS; r++) begin
              byte_cnt_r[r] <= '0;
              addr_r[r]     <= base_addr_i[r*ADDR_W +: ADDR_W];
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACTIVE: begin
          if (&row_done_r) begin
            state_r <= DONE;
            done_o  <= 1'b1;
          end else begin
            state_r <= ACTIVE;
          end
          for (int r = 0; r < ROWS; r++) begin
            if (write_back_finish[r] && !row_done_r[r]) begin
              flush_r[r] <= 1'b1;
            end
            if (inflight_s[r]) begin
              pend_r[r] <= 1'b0;
            end
            if (accept_s[r]) begin
              word_buf_r[r][{byte_cnt_r[r], 3'b000} +: 8] <= write_back_data_i[r*8 +: 8];
              if (byte_cnt_r[r] == CW'(WORD_BYTES-1)) begin
                pend_r[r]      <= 1'b1;
                word_mask_r[r] <= '1;
                byte_cnt_r[r]  <= '0;
              end else begin
                byte_cnt_r[r] <= byte_cnt_r[r] + CW'(1'b1);
              end
            end else if (flush_r[r] && !pend_r[r]) begin
              // Leftover bytes go out as a partial word; an empty buffer retires the row
              if (byte_cnt_r[r] != '0) begin
                pend_r[r]      <= 1'b1;
                word_mask_r[r] <= lane_mask(byte_cnt_r[r]);
                byte_cnt_r[r]  <= '0;
              end else begin
                row_done_r[r] <= 1'b1;
                flush_r[r]    <= 1'b0;
              end
            end else begin
              byte_cnt_r[r] <= byte_cnt_r[r];
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fm_wb_collector.sv
// Directed bench for fm_wb_collector: table of single-row flush cases plus
// hand-written sequences for latency, reset, all-row arbitration and address wrap.
module tb_fm_wb_collector;

  localparam int ROWS = 8;
  localparam int WB   = 8;
  localparam int AW   = 12;

  logic                 clk;
  logic                 rst;
  logic                 start_i;
  logic [ROWS*AW-1:0]   base_addr_i;
  logic [ROWS*8-1:0]    write_back_data_i;
  logic [ROWS-1:0]      write_back_data_i_valid;
  logic [ROWS-1:0]      fm_buf_ready;
  logic [ROWS-1:0]      write_back_finish;
  logic                 sram_wr_en;
  logic [AW-1:0]        sram_wr_addr;
  logic [WB*8-1:0]      sram_wr_data;
  logic [WB-1:0]        sram_wr_mask;
  logic                 done_o;

  fm_wb_collector #(.ROWS(ROWS), .WORD_BYTES(WB), .ADDR_W(AW)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .start_i                 (start_i),
    .base_addr_i             (base_addr_i),
    .write_back_data_i       (write_back_data_i),
    .write_back_data_i_valid (write_back_data_i_valid),
    .fm_buf_ready            (fm_buf_ready),
    .write_back_finish       (write_back_finish),
    .sram_wr_en              (sram_wr_en),
    .sram_wr_addr            (sram_wr_addr),
    .sram_wr_data            (sram_wr_data),
    .sram_wr_mask            (sram_wr_mask),
    .done_o                  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [AW-1:0]   wq_addr[$];
  logic [WB*8-1:0] wq_data[$];
  logic [WB-1:0]   wq_mask[$];
  int              done_cnt = 0;

  // Record every SRAM write and done pulse
  always @(negedge clk) begin
    if (sram_wr_en) begin
      wq_addr.push_back(sram_wr_addr);
      wq_data.push_back(sram_wr_data);
      wq_mask.push_back(sram_wr_mask);
    end
    if (done_o) done_cnt++;
  end

  typedef struct {
    int          row;
    int          nbytes;
    bit          fin_last;
    logic [11:0] base;
    int          exp_writes;
    logic [11:0] exp_addr;
    logic [63:0] exp_data;
    logic [7:0]  exp_mask;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_mask.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start_i = 1'b0;
    write_back_data_i_valid = '0;
    write_back_finish = '0;
    clear_log();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_byte(input int row, input logic [7:0] b, input logic fin);
    int n;
    n = 0;
    while (!fm_buf_ready[row] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("ready_timeout", 64'(row), 64'(99));
    write_back_data_i[row*8 +: 8] = b;
    write_back_data_i_valid[row]  = 1'b1;
    write_back_finish[row]        = fin;
    @(negedge clk);
    write_back_data_i_valid[row]  = 1'b0;
    write_back_finish[row]        = 1'b0;
  endtask

  task automatic pulse_finish(input logic [ROWS-1:0] m);
    write_back_finish = m;
    @(negedge clk);
    write_back_finish = '0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done_o && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(done_o), 64'(1));
    @(negedge clk);
    chk({nm, "_pulse"}, 64'(done_o), 64'(0));
  endtask

  initial begin
    int low;
    int en_at;
    logic [63:0]   ed;
    logic [ROWS-1:0] er;
    logic [ROWS-1:0] others;

    vecs[0] = '{2, 3,  1'b0, 12'h040, 1, 12'h040, 64'h0000_0000_0023_2221, 8'h07};
    vecs[1] = '{5, 8,  1'b1, 12'h123, 1, 12'h123, 64'h5857_5655_5453_5251, 8'hFF};
    vecs[2] = '{3, 1,  1'b0, 12'h7FE, 1, 12'h7FE, 64'h0000_0000_0000_0031, 8'h01};
    vecs[3] = '{7, 5,  1'b1, 12'hABC, 1, 12'hABC, 64'h0000_0075_7473_7271, 8'h1F};
    vecs[4] = '{0, 0,  1'b0, 12'h000, 0, 12'h000, 64'h0,                   8'h00};
    vecs[5] = '{6, 8,  1'b0, 12'h200, 1, 12'h200, 64'h6867_6665_6463_6261, 8'hFF};
    vecs[6] = '{4, 10, 1'b0, 12'h300, 2, 12'h301, 64'h0000_0000_0000_4A49, 8'h03};

    rst = 1'b1;
    start_i = 1'b0;
    base_addr_i = '0;
    write_back_data_i = '0;
    write_back_data_i_valid = '0;
    write_back_finish = '0;
    repeat (2) @(negedge clk);
    chk("rst_en",    64'(sram_wr_en),   64'(0));
    chk("rst_ready", 64'(fm_buf_ready), 64'(0));
    chk("rst_done",  64'(done_o),       64'(0));
    rst = 1'b0;

    // Full word on row 0: write two cycles after the 8th byte, ready low two cycles
    do_reset();
    base_addr_i = '0;
    base_addr_i[0*AW +: AW] = 12'h010;
    do_start();
    for (int i = 0; i < 8; i++) send_byte(0, 8'(i + 1), 1'b0);
    low = 0;
    en_at = -1;
    for (int k = 0; k < 4; k++) begin
      if (!fm_buf_ready[0]) low++;
      if (sram_wr_en && en_at < 0) begin
        en_at = k;
        chk("t2_addr", 64'(sram_wr_addr), 64'h010);
        chk("t2_data", sram_wr_data, 64'h0807_0605_0403_0201);
        chk("t2_mask", 64'(sram_wr_mask), 64'hFF);
      end
      @(negedge clk);
    end
    chk("t2_ready_low", 64'(low), 64'(2));
    chk("t2_latency", 64'(en_at), 64'(1));

    // Async reset with 3 bytes buffered: outputs drop at once, nothing written later
    for (int i = 0; i < 3; i++) send_byte(0, 8'(8'hA0 + i), 1'b0);
    rst = 1'b1;
    #1;
    chk("t1_ready", 64'(fm_buf_ready), 64'(0));
    chk("t1_en",    64'(sram_wr_en),   64'(0));
    chk("t1_addr",  64'(sram_wr_addr), 64'(0));
    chk("t1_data",  sram_wr_data,      64'(0));
    chk("t1_mask",  64'(sram_wr_mask), 64'(0));
    chk("t1_done",  64'(done_o),       64'(0));
    clear_log();
    @(negedge clk);
    rst = 1'b0;
    pulse_finish('1);
    repeat (10) @(negedge clk);
    chk("t1_no_write", 64'(wq_addr.size()), 64'(0));
    chk("t1_no_done",  64'(done_cnt),       64'(0));

    // Table: single-row partial/full flushes
    for (int v = 0; v < 7; v++) begin
      do_reset();
      base_addr_i = '0;
      base_addr_i[vecs[v].row*AW +: AW] = vecs[v].base;
      do_start();
      for (int i = 0; i < vecs[v].nbytes; i++) begin
        send_byte(vecs[v].row, 8'(vecs[v].row*16 + i + 1),
                  (i == vecs[v].nbytes - 1) ? vecs[v].fin_last : 1'b0);
      end
      if (!vecs[v].fin_last) begin
        others = '0;
        others[vecs[v].row] = 1'b1;
        pulse_finish(others);
      end
      others = '1;
      others[vecs[v].row] = 1'b0;
      pulse_finish(others);
      wait_done($sformatf("v%0d_done", v));
      @(negedge clk);
      chk($sformatf("v%0d_writes", v), 64'(wq_addr.size()), 64'(vecs[v].exp_writes));
      chk($sformatf("v%0d_done_cnt", v), 64'(done_cnt), 64'(1));
      if (vecs[v].exp_writes > 0 && wq_addr.size() > 0) begin
        chk($sformatf("v%0d_addr", v), 64'(wq_addr[wq_addr.size()-1]), 64'(vecs[v].exp_addr));
        chk($sformatf("v%0d_data", v), wq_data[wq_data.size()-1], vecs[v].exp_data);
        chk($sformatf("v%0d_mask", v), 64'(wq_mask[wq_mask.size()-1]), 64'(vecs[v].exp_mask));
      end
    end

    // All rows complete a word together: eight writes in row order
    do_reset();
    for (int r = 0; r < ROWS; r++) base_addr_i[r*AW +: AW] = 12'(r * 256 + 32);
    do_start();
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < ROWS; r++) write_back_data_i[r*8 +: 8] = 8'(r*16 + i + 1);
      write_back_data_i_valid = '1;
      @(negedge clk);
    end
    write_back_data_i_valid = '0;
    for (int k = 0; k < 10; k++) begin
      for (int r = 0; r < ROWS; r++) er[r] = (k >= r + 2);
      chk($sformatf("t4_ready_k%0d", k), 64'(fm_buf_ready), 64'(er));
      if (k >= 1 && k <= 8) begin
        for (int j = 0; j < 8; j++) ed[j*8 +: 8] = 8'((k-1)*16 + j + 1);
        chk($sformatf("t4_en_k%0d", k),   64'(sram_wr_en),   64'(1));
        chk($sformatf("t4_addr_k%0d", k), 64'(sram_wr_addr), 64'((k-1)*256 + 32));
        chk($sformatf("t4_data_k%0d", k), sram_wr_data,      ed);
      end else begin
        chk($sformatf("t4_idle_k%0d", k), 64'(sram_wr_en), 64'(0));
      end
      @(negedge clk);
    end
    pulse_finish('1);
    wait_done("t4_done");

    // Address wrap on row 1; a start during ACTIVE must not reload anything
    do_reset();
    base_addr_i = '0;
    base_addr_i[1*AW +: AW] = 12'hFFF;
    do_start();
    for (int i = 0; i < 8; i++) send_byte(1, 8'(16 + i + 1), 1'b0);
    base_addr_i[1*AW +: AW] = 12'h555;
    do_start();
    for (int i = 8; i < 16; i++) send_byte(1, 8'(16 + i + 1), 1'b0);
    pulse_finish('1);
    wait_done("t6_done");
    @(negedge clk);
    chk("t6_writes", 64'(wq_addr.size()), 64'(2));
    if (wq_addr.size() == 2) begin
      chk("t6_addr0", 64'(wq_addr[0]), 64'hFFF);
      chk("t6_addr1", 64'(wq_addr[1]), 64'h000);
      chk("t6_data1", wq_data[1], 64'h201F_1E1D_1C1B_1A19);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
